// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: md_op encodings,
// FSM states and datapath width.
package mdu_hilo_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/mdu_hilo_if.sv
// E-stage request/response bundle between the stall controller and the
// HI/LO unit; md_op stays a raw 3-bit field so undefined codes can be driven.
interface mdu_hilo_if;
    import mdu_hilo_pkg::*;

    logic              start;
    logic [2:0]        md_op;
    logic [DATA_W-1:0] rs_val;
    logic [DATA_W-1:0] rt_val;
    logic              busy;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;

    modport master (
        output start, md_op, rs_val, rt_val,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val,
        output busy, hi, lo
    );

endinterface

// File: rtl/mdu_calc.sv
// Combinational MULT/MULTU/DIV/DIVU evaluation; results are latched by the
// caller at operation start and committed after the fixed latency.
module mdu_calc
    import mdu_hilo_pkg::*;
(
    input  logic [2:0]        i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_div_zero
);

    function automatic logic [DATA_W-1:0] apply_sign(
        input logic              neg,
        input logic [DATA_W-1:0] mag
    );
        return neg ? (DATA_W'(0) - mag) : mag;
    endfunction

    logic signed [DATA_W-1:0]   w_a_s;
    logic signed [DATA_W-1:0]   w_b_s;
    logic signed [2*DATA_W-1:0] w_prod_s;
    logic [2*DATA_W-1:0]        w_prod_u;

    logic              w_is_signed_div;
    logic              w_neg_a;
    logic              w_neg_b;
    logic [DATA_W-1:0] w_mag_a;
    logic [DATA_W-1:0] w_mag_b;
    logic [DATA_W-1:0] w_q_mag;
    logic [DATA_W-1:0] w_r_mag;
    logic [DATA_W-1:0] w_quot;
    logic [DATA_W-1:0] w_rem;

    assign w_a_s    = i_a;
    assign w_b_s    = i_b;
    assign w_prod_s = (2*DATA_W)'(w_a_s) * (2*DATA_W)'(w_b_s);
    assign w_prod_u = (2*DATA_W)'(i_a) * (2*DATA_W)'(i_b);

    // Divide on magnitudes so the most negative dividend never overflows;
    // quotient truncates toward zero, remainder follows the dividend sign.
    assign w_is_signed_div = (i_op == MD_DIV);
    assign w_neg_a = w_is_signed_div & i_a[DATA_W-1];
    assign w_neg_b = w_is_signed_div & i_b[DATA_W-1];
    assign w_mag_a = apply_sign(w_neg_a, i_a);
    assign w_mag_b = apply_sign(w_neg_b, i_b);
    assign w_q_mag = (w_mag_b == '0) ? '0 : (w_mag_a / w_mag_b);
    assign w_r_mag = (w_mag_b == '0) ? '0 : (w_mag_a % w_mag_b);
    assign w_quot  = apply_sign(w_neg_a ^ w_neg_b, w_q_mag);
    assign w_rem   = apply_sign(w_neg_a, w_r_mag);

    always_comb begin
        o_hi       = '0;
        o_lo       = '0;
        o_div_zero = 1'b0;
        case (i_op)
            MD_MULT: begin
                o_hi = w_prod_s[2*DATA_W-1:DATA_W];
                o_lo = w_prod_s[DATA_W-1:0];
            end
            MD_MULTU: begin
                o_hi = w_prod_u[2*DATA_W-1:DATA_W];
                o_lo = w_prod_u[DATA_W-1:0];
            end
            MD_DIV, MD_DIVU: begin
                o_hi       = w_rem;
                o_lo       = w_quot;
                o_div_zero = (i_b == '0);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit: fixed-latency MULT/DIV with HI/LO commit,
// single-cycle MTHI/MTLO, and a registered busy flag for the stall logic.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    mdu_hilo_if.slave md
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_launch;
    logic              w_commit;
    logic              w_wr_hi;
    logic              w_wr_lo;

    logic [DATA_W-1:0] r_hi;
    logic [DATA_W-1:0] r_lo;
    logic [DATA_W-1:0] r_tmp_hi;
    logic [DATA_W-1:0] r_tmp_lo;
    logic              r_tmp_dz;

    logic [DATA_W-1:0] w_calc_hi;
    logic [DATA_W-1:0] w_calc_lo;
    logic              w_calc_dz;

    mdu_calc u_calc (
        .i_op       (md.md_op),
        .i_a        (md.rs_val),
        .i_b        (md.rt_val),
        .o_hi       (w_calc_hi),
        .o_lo       (w_calc_lo),
        .o_div_zero (w_calc_dz)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // start is only honoured in IDLE; anything arriving during RUN is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_launch    = 1'b0;
        w_commit    = 1'b0;
        w_wr_hi     = 1'b0;
        w_wr_lo     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (md.start) begin
                    case (md.md_op)
                        MD_MULT, MD_MULTU: begin
                            w_launch    = 1'b1;
                            w_state_nxt = ST_RUN;
                            w_cnt_nxt   = CNT_W'(MUL_CYCLES);
                        end
                        MD_DIV, MD_DIVU: begin
                            w_launch    = 1'b1;
                            w_state_nxt = ST_RUN;
                            w_cnt_nxt   = CNT_W'(DIV_CYCLES);
                        end
                        MD_MTHI: w_wr_hi = 1'b1;
                        MD_MTLO: w_wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_tmp_hi <= '0;
            r_tmp_lo <= '0;
            r_tmp_dz <= 1'b0;
        end else begin
            if (w_launch) begin
                r_tmp_hi <= w_calc_hi;
                r_tmp_lo <= w_calc_lo;
                r_tmp_dz <= w_calc_dz;
            end
            // Divide by zero still occupies the unit but leaves HI/LO intact.
            if (w_commit && !r_tmp_dz) begin
                r_hi <= r_tmp_hi;
                r_lo <= r_tmp_lo;
            end
            if (w_wr_hi) r_hi <= md.rs_val;
            if (w_wr_lo) r_lo <= md.rs_val;
        end
    end

    assign md.busy = (r_state == ST_RUN);
    assign md.hi   = r_hi;
    assign md.lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: vector table through a result scoreboard, plus
// hand-written sequences for MT writes, ignored starts and mid-flight reset.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    localparam int MULN = 5;
    localparam int DIVN = 10;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        keep;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    res_t sb_q[$];
    vec_t vecs[14];

    mdu_hilo_if u_if();

    mdu_hilo #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        u_if.start  = 1'b1;
        u_if.md_op  = op;
        u_if.rs_val = a;
        u_if.rt_val = b;
        check({nm, "_busy_at_start"}, {31'd0, u_if.busy}, 32'd0);
        @(negedge clk);
        u_if.start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int n);
        int   cnt;
        res_t exp;
        cnt = 0;
        while (u_if.busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check({nm, "_busy_cycles"}, 32'(cnt), 32'(n));
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s_scoreboard actual=empty required=entry", nm);
        end else begin
            exp = sb_q.pop_front();
            check({nm, "_hi"}, u_if.hi, exp.hi);
            check({nm, "_lo"}, u_if.lo, exp.lo);
        end
    endtask

    task automatic push_exp(input logic [31:0] h, input logic [31:0] l);
        res_t r;
        r.hi = h;
        r.lo = l;
        sb_q.push_back(r);
        m_hi = h;
        m_lo = l;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        m_hi     = '0;
        m_lo     = '0;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'd2,        1'b0, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MD_DIVU,  32'd7,        32'd0,        1'b1, 32'h0,        32'h0};
        vecs[4]  = '{MD_MULT,  32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000};
        vecs[5]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[6]  = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h00000001};
        vecs[7]  = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h3FFFFFFF, 32'h00000001};
        vecs[8]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 1'b0, 32'h0000000F, 32'h0FFFFFFF};
        vecs[10] = '{MD_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFE, 32'h00000002};
        vecs[11] = '{MD_DIV,   32'd5,        32'd0,        1'b1, 32'h0,        32'h0};
        vecs[12] = '{MD_DIVU,  32'd100,      32'd7,        1'b0, 32'h00000002, 32'h0000000E};
        vecs[13] = '{MD_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFF, 32'h80000001};

        reset       = 1'b0;
        u_if.start  = 1'b0;
        u_if.md_op  = 3'd0;
        u_if.rs_val = '0;
        u_if.rt_val = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'd0, u_if.busy}, 32'd0);
        check("reset_hi", u_if.hi, 32'd0);
        check("reset_lo", u_if.lo, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].keep) push_exp(m_hi, m_lo);
            else              push_exp(vecs[i].hi, vecs[i].lo);
            issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("vec%0d", i), (vecs[i].op == MD_MULT || vecs[i].op == MD_MULTU) ? MULN : DIVN);
        end

        // MTLO then MTHI: visible next cycle, never busy
        issue("mtlo", MD_MTLO, 32'h12345678, 32'h0);
        check("mtlo_lo", u_if.lo, 32'h12345678);
        check("mtlo_hi_kept", u_if.hi, m_hi);
        check("mtlo_busy", {31'd0, u_if.busy}, 32'd0);
        m_lo = 32'h12345678;
        issue("mthi", MD_MTHI, 32'hA5A5A5A5, 32'h0);
        check("mthi_hi", u_if.hi, 32'hA5A5A5A5);
        check("mthi_lo_kept", u_if.lo, 32'h12345678);
        check("mthi_busy", {31'd0, u_if.busy}, 32'd0);
        m_hi = 32'hA5A5A5A5;

        // undefined op codes are ignored
        issue("undef6", 3'd6, 32'h11111111, 32'h2);
        check("undef6_busy", {31'd0, u_if.busy}, 32'd0);
        issue("undef7", 3'd7, 32'h22222222, 32'h3);
        check("undef7_busy", {31'd0, u_if.busy}, 32'd0);
        check("undef_hi", u_if.hi, m_hi);
        check("undef_lo", u_if.lo, m_lo);

        // starts during RUN (MULT, then MTHI) are dropped
        push_exp(32'h0, 32'd6);
        issue("inject", MD_MULT, 32'd2, 32'd3);
        u_if.start  = 1'b1;
        u_if.md_op  = MD_MULT;
        u_if.rs_val = 32'd5;
        u_if.rt_val = 32'd5;
        @(negedge clk);
        u_if.md_op  = MD_MTHI;
        u_if.rs_val = 32'hDEADBEEF;
        @(negedge clk);
        u_if.start = 1'b0;
        wait_done("inject", MULN - 2);
        repeat (3) @(negedge clk);
        check("inject_no_restart", {31'd0, u_if.busy}, 32'd0);

        // back-to-back: MULT completes, MTHI immediately after
        push_exp(32'hFFFFFFFF, 32'hFFFFFFEB);
        issue("b2b_mult", MD_MULT, 32'hFFFFFFFD, 32'd7);
        wait_done("b2b_mult", MULN);
        issue("b2b_mthi", MD_MTHI, 32'hCAFEF00D, 32'h0);
        check("b2b_hi", u_if.hi, 32'hCAFEF00D);
        check("b2b_lo", u_if.lo, 32'hFFFFFFEB);

        // reset on the 4th busy cycle of a DIV abandons it
        issue("rst_div", MD_DIV, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        check("rst_div_busy_before", {31'd0, u_if.busy}, 32'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("rst_div_busy", {31'd0, u_if.busy}, 32'd0);
        check("rst_div_hi", u_if.hi, 32'd0);
        check("rst_div_lo", u_if.lo, 32'd0);
        repeat (12) @(negedge clk);
        check("rst_div_no_commit_busy", {31'd0, u_if.busy}, 32'd0);
        check("rst_div_no_commit_hi", u_if.hi, 32'd0);
        check("rst_div_no_commit_lo", u_if.lo, 32'd0);

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with HI/LO registers in the E stage of the five-stage MIPS pipeline. It answers the stall controller: the controller issues md-type instructions, and this block reports `start`/`busy` back so that any md-type instruction in D stalls while an operation is in flight. It executes MULT/MULTU/DIV/DIVU with fixed multi-cycle latency, handles MTHI/MTLO as single-cycle writes, and presents HI/LO for MFHI/MFLO forwarding into the E-stage result mux.

## Interface
Parameters:
- `MUL_CYCLES`, 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low; acts only on a rising `clk` edge while 0.
- `start`  in  1  E-stage instruction is an md-type op; valid for one cycle.
- `md_op`  in  3  op code from `def.v`: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- `rs_val`  in  32  forwarded E-stage rs operand.
- `rt_val`  in  32  forwarded E-stage rt operand.
- `busy`  out  1  operation in flight; stall controller stalls D md-type instructions when `start | busy`.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- States: IDLE, RUN.
- IDLE + `start` + MULT/MULTU/DIV/DIVU → RUN. Operands are latched, the result is computed into `tmp_hi`/`tmp_lo`, and `cnt` is loaded with `MUL_CYCLES` or `DIV_CYCLES`.
- RUN: `cnt` decrements each cycle. At `cnt == 1` the state returns to IDLE and `tmp_hi`/`tmp_lo` are committed to `hi`/`lo`.
- MULT: signed 32×32 → 64; `hi` = [63:32], `lo` = [31:0]. MULTU: unsigned.
- DIV: signed; `lo` = quotient truncated toward zero; `hi` = remainder with the sign of the dividend. DIVU: unsigned.
- Divide by zero: the unit runs the full `DIV_CYCLES`, and `hi`/`lo` are left unchanged at commit.
- MTHI/MTLO + `start` in IDLE: `hi`/`lo` is written from `rs_val` at the next edge. The state stays IDLE and `busy` stays 0.
- `start` while RUN: ignored. The controller guarantees this does not happen; the bench checks that it has no effect.
- Undefined `md_op` with `start`: ignored.
- Reset at 0 on an edge: state = IDLE, `cnt` = 0, `busy` = 0, `hi` = `lo` = 0, temporaries cleared. An in-flight operation is abandoned with no commit.

## Timing
- `busy` is registered (= state==RUN). It is 0 during the `start` cycle T, 1 for cycles T+1 … T+N, and 0 at T+N+1.
- N = `MUL_CYCLES` or `DIV_CYCLES`.
- `hi`/`lo` take the new values at the edge ending cycle T+N and are visible at T+N+1.
- MTHI/MTLO issued at T is visible at T+1.
- MFHI/MFLO read combinationally from `hi`/`lo`. The controller stalls them while `start | busy`, so no bypass of `tmp_*` exists.

## Structure
- `def.v` holds the `md_op` encodings (MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5) and the md-type class used by `AT_encoder`.
- One sub-module `mdu_calc`: combinational 64-bit product/quotient/remainder from op + operands. It feeds `tmp_hi`/`tmp_lo`.
- The FSM, counter and HI/LO registers live in `mdu_hilo`.

## Test plan
- MULT −3 × 7 at T → `busy` 1 for T+1..T+5; at T+6 `hi` = 0xFFFFFFFF, `lo` = 0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 2 → after 5 busy cycles `hi` = 0x00000001, `lo` = 0xFFFFFFFE.
- DIV −7 / 2 → `busy` 10 cycles; then `lo` = 0xFFFFFFFD (−3), `hi` = 0xFFFFFFFF (−1). DIVU 7 / 0 → `hi`/`lo` unchanged after 10 cycles.
- MTLO rs = 0x12345678 → `lo` = 0x12345678 the next cycle, `busy` never 1. A second `start` with MULT during RUN → no restart; the original result commits on schedule.
- DIV started, then reset=0 on the 4th busy cycle → next cycle `busy` = 0, `hi` = `lo` = 0, no later commit.
- Back-to-back: MULT completes, then MTHI at T+6 → `hi` = rs at T+7 and `lo` keeps the MULT value.
